// File: rtl/i281_loader_pkg.sv
// Shared types and widths for the i281 BIOS loader.
package i281_loader_pkg;

  localparam int unsigned CM_ADDR_W  = 6;
  localparam int unsigned CM_WORD_W  = 16;
  localparam int unsigned CM_COUNT_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/i281_bios_loader_key_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// registered one-cycle press pulse on the accepted level's rising edge.
module key_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             level_prev_q;
  logic             press_q;

  // Level flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_raw};
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/i281_bios_loader.sv
// Code-memory loader for the i281 CPU: writes one switch word per load press
// and holds the CPU in reset until a run press or a full memory.
module i281_bios_loader
  import i281_loader_pkg::*;
#(
  parameter int unsigned CM_DEPTH        = 64,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CM_WORD_W-1:0]  switches,
  input  logic                  load_key,
  input  logic                  run_key,
  output logic                  cm_write_en,
  output logic [CM_ADDR_W-1:0]  cm_write_sel,
  output logic [CM_WORD_W-1:0]  cm_data,
  output logic                  cpu_reset_n,
  output logic [CM_COUNT_W-1:0] words_loaded,
  output logic [1:0]            loader_state
);

  localparam logic [CM_ADDR_W-1:0] LAST_ADDR = CM_ADDR_W'(CM_DEPTH - 1);

  logic load_press;
  logic run_press;

  loader_state_t         state_q, state_d;
  logic [CM_ADDR_W-1:0]  addr_q, addr_d;
  logic [CM_COUNT_W-1:0] words_q, words_d;
  logic [CM_ADDR_W-1:0]  sel_q, sel_d;
  logic [CM_WORD_W-1:0]  data_q, data_d;
  logic                  we_q, we_d;
  logic                  cpu_rn_q, cpu_rn_d;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (load_key),
    .press   (load_press)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_raw (run_key),
    .press   (run_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      words_q  <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      cpu_rn_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      words_q  <= words_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      we_q     <= we_d;
      cpu_rn_q <= cpu_rn_d;
    end
  end

  // Run wins over load; presses during WRITE are not looked at.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (run_press)       state_d = RUN;
        else if (load_press) state_d = ARMED;
      end
      ARMED: begin
        if (run_press)       state_d = RUN;
        else if (load_press) state_d = WRITE;
      end
      WRITE: begin
        state_d = (addr_q == LAST_ADDR) ? RUN : ARMED;
      end
      RUN: begin
        if (load_press)      state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs, keyed on the transition taken.
  always_comb begin
    addr_d   = addr_q;
    words_d  = words_q;
    sel_d    = sel_q;
    data_d   = data_q;
    we_d     = (state_d == WRITE);
    cpu_rn_d = (state_d == RUN);

    if ((state_q == IDLE || state_q == RUN) && state_d == ARMED) begin
      addr_d  = '0;
      words_d = '0;
    end

    if (state_d == WRITE) begin
      sel_d  = addr_q;
      data_d = switches;
    end

    // The last address is held so the pointer never wraps.
    if (state_q == WRITE) begin
      words_d = words_q + CM_COUNT_W'(1);
      if (addr_q != LAST_ADDR) addr_d = addr_q + CM_ADDR_W'(1);
    end
  end

  assign cm_write_en  = we_q;
  assign cm_write_sel = sel_q;
  assign cm_data      = data_q;
  assign cpu_reset_n  = cpu_rn_q;
  assign words_loaded = words_q;
  assign loader_state = 2'(state_q);

endmodule

// File: doc/i281_bios_loader.md
# i281_bios_loader

Front-end loader sitting directly upstream of the i281 CPU's code memory. It steps through code-memory addresses from the board switches and a load key, writing one 16-bit instruction per key press. It holds the CPU in reset while loading and releases it on a run key or once memory is full. It drives the code-memory write port (write enable, write select, write data) and the CPU reset line.

## Interface
Parameters:
- CM_DEPTH, 64: number of code-memory words; write address width is 6.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised samples required before a key level is accepted. Minimum 2.

Ports:
- Clock  in  1  single system clock for all state.
- Reset  in  1  asynchronous, active-low. All state clears immediately on assertion; release is synchronous to Clock.
- Switches  in  16  instruction word to load. Sampled only on the write cycle.
- load_key  in  1  raw push button, active-high. Asynchronous to Clock and may bounce.
- run_key  in  1  raw push button, active-high. Asynchronous to Clock and may bounce.
- cm_write_en  out  1  code-memory write enable; a one-cycle pulse per word.
- cm_write_sel  out  6  code-memory write address.
- cm_data  out  16  code-memory write data.
- cpu_reset_n  out  1  active-low reset to the CPU; 1 only in RUN.
- words_loaded  out  7  count of words written since the last ARMED entry (0..CM_DEPTH).
- loader_state  out  2  current FSM state, for LEDs.

## Operation
- Each key path:
  - 2-flop synchroniser.
  - Debounce counter: the accepted level changes only after DEBOUNCE_CYCLES consecutive samples differ from it; any mismatch-free sample restarts the count.
  - Rising-edge detect on the accepted level produces a one-cycle press pulse.
- FSM states: IDLE=0, ARMED=1, WRITE=2, RUN=3. Reset state is IDLE.
- IDLE:
  - load press -> ARMED; addr=0, words_loaded=0.
  - run press -> RUN.
- ARMED:
  - run press -> RUN. This takes priority over a load press in the same cycle.
  - Otherwise load press -> WRITE.
- WRITE (exactly one cycle):
  - cm_write_en=1, cm_write_sel=addr, cm_data=Switches captured at the entering edge.
  - Next edge: words_loaded+1. If addr==CM_DEPTH-1 -> RUN, with addr held at CM_DEPTH-1. Else addr+1 -> ARMED.
  - Key presses arriving during WRITE are dropped.
- RUN:
  - cpu_reset_n=1.
  - load press -> ARMED with addr=0 and words_loaded=0; cpu_reset_n drops at the same edge.
  - run press is ignored.
- Address never wraps; a full load auto-transitions to RUN.
- All outputs are registered.

## Timing
- Reset values:
  - cm_write_en=0, cm_write_sel=0, cm_data=0, cpu_reset_n=0, words_loaded=0, loader_state=0.
  - Synchronisers, debounce counters, and accepted levels all at 0.
- Press latency: a clean raw edge reaches the FSM press pulse after 2 sync cycles + DEBOUNCE_CYCLES + 1 edge cycle. The state changes on the following edge.
- Write pulse: cm_write_en is high for exactly one cycle. cm_write_sel and cm_data are stable for that whole cycle and hold their values afterwards.
- Transitions into or out of RUN change cpu_reset_n at the same edge as loader_state.
- A key held down produces exactly one press. Bounce shorter than DEBOUNCE_CYCLES produces none.
- Reset asserted mid-WRITE: cm_write_en drops asynchronously, and that word is not counted.

## Structure
- Package i281_loader_pkg holds:
  - loader_state_t enum (IDLE, ARMED, WRITE, RUN).
  - CM_ADDR_W=6 and CM_WORD_W=16 constants.
- One sub-module, key_debouncer (synchroniser + debounce counter + edge pulse), parameterised by DEBOUNCE_CYCLES. It is instantiated once for load_key and once for run_key.
- The FSM, address counter, and output registers live in the top module.

## Test plan
- Reset sequencing:
  - Stimulus: assert Reset=0 mid-run, then release.
  - Required response: all outputs go to reset values immediately; loader_state=IDLE; cpu_reset_n=0.
- Three-word load:
  - Stimulus: load press (arm), then three load presses with Switches=16'h1234, 16'hABCD, 16'h0001.
  - Required response: three single-cycle cm_write_en pulses at sel 0, 1, 2 with matching data; words_loaded=3.
  - Follow-up: run press -> cpu_reset_n=1, loader_state=3.
- Bounce rejection (DEBOUNCE_CYCLES=16):
  - Stimulus: in ARMED, 5-cycle glitches on load_key, then a key held for 200 cycles.
  - Required response: exactly one write; no write from the glitches.
- Full memory:
  - Stimulus: 64 writes.
  - Required response: last write at sel 63; auto-transition to RUN on the next edge; words_loaded=64; no 65th write.
- Simultaneous keys:
  - Stimulus: load and run presses land in the same cycle in ARMED.
  - Required response: RUN entered; no cm_write_en pulse.
- Reload from RUN:
  - Stimulus: load press while in RUN.
  - Required response: cpu_reset_n=0, loader_state=ARMED, words_loaded=0.
  - Follow-up: next write goes to sel 0.
